// File: rtl/led_chaser_param.sv
// Bouncing/wrapping LED block chaser with prescaled step tick and per-end colour toggle.
// Optional bicolour operation is enabled by defining LED_CHASER_BICOLOR_EN; otherwise the block is always red.
module led_chaser_param #(
    parameter int N_LEDS  = 8,
    parameter int BLOCK_W = 3,
    parameter int DIV_W   = 20,
    localparam int PW     = $clog2(N_LEDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [1:0]        speed,
    output logic [N_LEDS-1:0] led_red,
    output logic [N_LEDS-1:0] led_green,
    output logic [PW-1:0]     pos,
    output logic              dir,
    output logic              turn,
    output logic              ctl_bit
);

    localparam logic [1:0] MODE_BOUNCE = 2'b00;
    localparam logic [1:0] MODE_WRAP_L = 2'b01;
    localparam logic [1:0] MODE_WRAP_R = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    localparam logic [PW-1:0]     POS_MAX = PW'(N_LEDS - BLOCK_W);
    localparam logic [N_LEDS-1:0] BLK     = N_LEDS'((1 << BLOCK_W) - 1);

    logic [DIV_W-1:0]  cnt;
    logic [DIV_W-1:0]  mask;
    logic              tick;
    logic              green;
    logic              green_nx;
    logic [PW-1:0]     pos_nx;
    logic              dir_nx;
    logic              end_evt;
    logic [N_LEDS-1:0] lit_nx;

    // Only the low DIV_W-speed prescaler bits take part in the tick compare.
    assign mask = {DIV_W{1'b1}} >> speed;
    assign tick = enable && ((cnt & mask) == mask);

    always_comb begin
        pos_nx  = pos;
        dir_nx  = dir;
        end_evt = 1'b0;
        if (tick) begin
            case (mode)
                MODE_BOUNCE: begin
                    if (!dir) begin
                        if (pos == '0) begin
                            dir_nx  = 1'b1;
                            pos_nx  = PW'(1);
                            end_evt = 1'b1;
                        end else begin
                            pos_nx = pos - 1'b1;
                        end
                    end else begin
                        if (pos == POS_MAX) begin
                            dir_nx  = 1'b0;
                            pos_nx  = POS_MAX - 1'b1;
                            end_evt = 1'b1;
                        end else begin
                            pos_nx = pos + 1'b1;
                        end
                    end
                end
                MODE_WRAP_R: begin
                    dir_nx = 1'b0;
                    if (pos == '0) begin
                        pos_nx  = POS_MAX;
                        end_evt = 1'b1;
                    end else begin
                        pos_nx = pos - 1'b1;
                    end
                end
                MODE_WRAP_L: begin
                    dir_nx = 1'b1;
                    if (pos == POS_MAX) begin
                        pos_nx  = '0;
                        end_evt = 1'b1;
                    end else begin
                        pos_nx = pos + 1'b1;
                    end
                end
                MODE_HOLD: begin
                    pos_nx = pos;
                end
                default: begin
                    pos_nx = pos;
                end
            endcase
        end
    end

`ifdef LED_CHASER_BICOLOR_EN
    assign green_nx = green ^ end_evt;
`else
    assign green_nx = 1'b0;
`endif

    assign lit_nx  = BLK << pos_nx;
    assign ctl_bit = 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            pos       <= POS_MAX;
            dir       <= 1'b0;
            green     <= 1'b0;
            turn      <= 1'b0;
            led_red   <= BLK << POS_MAX;
            led_green <= '0;
        end else begin
            if (enable) begin
                cnt <= cnt + 1'b1;
            end
            pos       <= pos_nx;
            dir       <= dir_nx;
            green     <= green_nx;
            turn      <= end_evt;
            led_red   <= green_nx ? '0 : lit_nx;
            led_green <= green_nx ? lit_nx : '0;
        end
    end

endmodule

// File: tb/tb_led_chaser_param.sv
// Scoreboard bench for led_chaser_param (N_LEDS=8, BLOCK_W=3, DIV_W=4): expected pattern steps are queued
// by the stimulus and popped by a monitor whenever the displayed pattern changes, including the clk gap since the last change.
module tb_led_chaser_param;

    typedef struct packed {
        logic [7:0]  red;
        logic [7:0]  green;
        logic [2:0]  pos;
        logic        dir;
        logic        turn;
        logic [31:0] gap;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [1:0] speed = 2'b00;
    logic [7:0] led_red;
    logic [7:0] led_green;
    logic [2:0] pos;
    logic       dir;
    logic       turn;
    logic       ctl_bit;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    led_chaser_param #(.N_LEDS(8), .BLOCK_W(3), .DIV_W(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .speed(speed),
        .led_red(led_red), .led_green(led_green), .pos(pos), .dir(dir),
        .turn(turn), .ctl_bit(ctl_bit)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Without the bicolour build every lit LED shows up on the red bank.
    function automatic void expect_step(input logic [7:0] r, input logic [7:0] g, input logic [2:0] p,
                                        input logic d, input logic t, input int gap);
        exp_t e;
`ifndef LED_CHASER_BICOLOR_EN
        r = r | g;
        g = 8'h00;
`endif
        e.red = r; e.green = g; e.pos = p; e.dir = d; e.turn = t; e.gap = gap;
        q.push_back(e);
    endfunction

    // Monitor: a change of the displayed pattern is the output event.
    initial begin : monitor
        logic [19:0] prev;
        logic [19:0] now;
        int          last;
        exp_t        e;
        prev = '0;
        last = 0;
        forever begin
            @(negedge clk);
            cyc++;
            now = {led_red, led_green, pos, dir};
            if (reset) begin
                last = cyc;
            end else if (now != prev) begin
                if (q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_change: got red=%b green=%b pos=%0d, required no change", led_red, led_green, pos);
                end else begin
                    e = q.pop_front();
                    check("led_red", led_red, e.red);
                    check("led_green", led_green, e.green);
                    check("pos", pos, e.pos);
                    check("dir", dir, e.dir);
                    check("turn", turn, e.turn);
                    if (e.gap != 0) check("step_gap", cyc - last, e.gap);
                end
                last = cyc;
            end else if (turn) begin
                check("turn_idle", turn, 1'b0);
            end
            prev = now;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_q(input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("queue_drained", q.size(), 0);
        q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("rst_led_red", led_red, 8'hE0);
        check("rst_led_green", led_green, 8'h00);
        check("rst_pos", pos, 3'd5);
        check("rst_dir", dir, 1'b0);
        check("rst_turn", turn, 1'b0);
        check("rst_ctl_bit", ctl_bit, 1'b1);
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin : stimulus
        enable = 1'b1;

        // Bounce, full cycle, with a 100-clk enable freeze after the first step.
        mode = 2'b00; speed = 2'd0;
        do_reset();
        expect_step(8'h70, 8'h00, 3'd4, 1'b0, 1'b0, 16);
        expect_step(8'h38, 8'h00, 3'd3, 1'b0, 1'b0, 116);
        expect_step(8'h1C, 8'h00, 3'd2, 1'b0, 1'b0, 16);
        expect_step(8'h0E, 8'h00, 3'd1, 1'b0, 1'b0, 16);
        expect_step(8'h07, 8'h00, 3'd0, 1'b0, 1'b0, 16);
        expect_step(8'h00, 8'h0E, 3'd1, 1'b1, 1'b1, 16);
        expect_step(8'h00, 8'h1C, 3'd2, 1'b1, 1'b0, 16);
        expect_step(8'h00, 8'h38, 3'd3, 1'b1, 1'b0, 16);
        expect_step(8'h00, 8'h70, 3'd4, 1'b1, 1'b0, 16);
        expect_step(8'h00, 8'hE0, 3'd5, 1'b1, 1'b0, 16);
        expect_step(8'h70, 8'h00, 3'd4, 1'b0, 1'b1, 16);
        wait_cyc(21);
        enable = 1'b0;
        wait_cyc(100);
        check("frozen_pos", pos, 3'd4);
        check("frozen_led_red", led_red, 8'h70);
        enable = 1'b1;
        wait_q(400);

        // Wrap-right from reset.
        mode = 2'b10;
        do_reset();
        expect_step(8'h70, 8'h00, 3'd4, 1'b0, 1'b0, 16);
        expect_step(8'h38, 8'h00, 3'd3, 1'b0, 1'b0, 16);
        expect_step(8'h1C, 8'h00, 3'd2, 1'b0, 1'b0, 16);
        expect_step(8'h0E, 8'h00, 3'd1, 1'b0, 1'b0, 16);
        expect_step(8'h07, 8'h00, 3'd0, 1'b0, 1'b0, 16);
        expect_step(8'h00, 8'hE0, 3'd5, 1'b0, 1'b1, 16);
        wait_q(200);

        // Wrap-left from reset: the top end wraps straight to index 0.
        mode = 2'b01;
        do_reset();
        expect_step(8'h00, 8'h07, 3'd0, 1'b1, 1'b1, 16);
        expect_step(8'h00, 8'h0E, 3'd1, 1'b1, 1'b0, 16);
        wait_q(100);

        // Fast speed, a hold interval, then resume and reset while pos=2 in green.
        mode = 2'b00; speed = 2'd2;
        do_reset();
        expect_step(8'h70, 8'h00, 3'd4, 1'b0, 1'b0, 4);
        expect_step(8'h38, 8'h00, 3'd3, 1'b0, 1'b0, 4);
        expect_step(8'h1C, 8'h00, 3'd2, 1'b0, 1'b0, 4);
        wait_q(40);
        mode = 2'b11;
        wait_cyc(40);
        check("hold_pos", pos, 3'd2);
        check("hold_led_red", led_red, 8'h1C);
        mode = 2'b00;
        expect_step(8'h0E, 8'h00, 3'd1, 1'b0, 1'b0, 44);
        expect_step(8'h07, 8'h00, 3'd0, 1'b0, 1'b0, 4);
        expect_step(8'h00, 8'h0E, 3'd1, 1'b1, 1'b1, 4);
        expect_step(8'h00, 8'h1C, 3'd2, 1'b1, 1'b0, 4);
        wait_q(100);
        wait_cyc(1);
        do_reset();
        wait_cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/led_chaser_param.md
LED_CHASER_PARAM -- requirements
Module: led_chaser_param

Interface
REQ-001 Parameter N_LEDS, default 8: number of LEDs per colour; SHALL be >= BLOCK_W+1.
REQ-002 Parameter BLOCK_W, default 3: number of adjacent lit LEDs in the moving block; SHALL be >= 1.
REQ-003 Parameter DIV_W, default 20: prescaler width; SHALL be >= 4.
REQ-004 clk  input  1  system clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  1 = run prescaler; 0 = freeze prescaler and pattern.
REQ-007 mode  input  2  00 bounce, 01 wrap-left, 10 wrap-right, 11 hold.
REQ-008 speed  input  2  step period select.
REQ-009 led_red  output  N_LEDS  red LED drive, active-high.
REQ-010 led_green  output  N_LEDS  green LED drive, active-high.
REQ-011 pos  output  $clog2(N_LEDS)  index of the lowest lit LED of the block.
REQ-012 dir  output  1  0 = moving toward index 0, 1 = toward index N_LEDS-1.
REQ-013 turn  output  1  one-cycle pulse on each colour toggle.
REQ-014 ctl_bit  output  1  LED bank enable, constant 1.

Function
REQ-015 Prescaler: DIV_W-bit counter, +1 per clk while enable=1, wraps to 0; holds while enable=0.
REQ-016 tick is asserted for exactly one clk when enable=1 and the low (DIV_W-speed) counter bits are all ones; step period = 2^(DIV_W-speed) clk.
REQ-017 Lit set = LEDs pos .. pos+BLOCK_W-1; pos range 0 .. N_LEDS-BLOCK_W.
REQ-018 Colour state red: led_red = lit set, led_green = 0; green: led_green = lit set, led_red = 0.
REQ-019 All outputs are registered; a pattern change is visible on the clk edge after the tick cycle.
REQ-020 Bounce, dir=0, pos>0: pos -> pos-1. Bounce, dir=0, pos=0: dir -> 1, colour toggles, pos -> 1, turn=1.
REQ-021 Bounce, dir=1, pos<N_LEDS-BLOCK_W: pos -> pos+1. Bounce, dir=1, pos=N_LEDS-BLOCK_W: dir -> 0, colour toggles, pos -> N_LEDS-BLOCK_W-1, turn=1.
REQ-022 Wrap-right: dir forced 0; pos=0 -> pos N_LEDS-BLOCK_W, colour toggles, turn=1; otherwise pos-1.
REQ-023 Wrap-left: dir forced 1; pos=N_LEDS-BLOCK_W -> pos 0, colour toggles, turn=1; otherwise pos+1.
REQ-024 Hold: pos, dir and colour unchanged on tick; turn stays 0.
REQ-025 A mode change takes effect at the next tick only; dir is updated at that tick.
REQ-026 A speed change takes effect immediately; the prescaler is not cleared.
REQ-027 Without a tick, pos, dir and colour hold; turn=0.

Reset
REQ-028 reset asserted: prescaler 0, pos N_LEDS-BLOCK_W, dir 0, colour red, turn 0, led_red bits N_LEDS-1..N_LEDS-BLOCK_W = 1, led_green 0, ctl_bit 1.
REQ-029 Reset mid-operation overrides all in-flight state immediately; the first tick after release occurs 2^(DIV_W-speed) clk later.

Configuration
REQ-030 Macro LED_CHASER_BICOLOR_EN defined: colour toggles as in REQ-020..REQ-023.
REQ-031 Macro undefined: colour stays red; led_green is constant 0; turn still pulses at each end event.

Verification (N_LEDS=8, BLOCK_W=3, DIV_W=4, speed=0, macro defined)
REQ-032 Reset, bounce, 6 ticks -> led_red 11100000, 01110000, 00111000, 00011100, 00001110, 00000111, then led_green 00001110 with turn=1, dir=1.
REQ-033 Bounce, run to led_green 11100000 -> next tick gives led_red 01110000, turn=1, dir=0; full cycle is 10 ticks.
REQ-034 Wrap-right from reset, 6 ticks -> pos 5,4,3,2,1,0, then pos 5 in green with turn=1.
REQ-035 enable=0 for 100 clk mid-pattern -> outputs unchanged; after re-enable, the next tick arrives after the remaining prescaler count.
REQ-036 speed=2 -> ticks every 4 clk; mode=11 -> pattern frozen, no turn pulse.
REQ-037 reset pulsed while pos=2 in green -> immediately led_red 11100000, pos 5, dir 0.
